// File: rtl/disp_link_pkg.sv
// Shared types and constants for the display shift-register link.
// Receivers and drivers both import this package.
package disp_link_pkg;

  typedef enum logic {IDLE, SHIFT} rx_state_t;

  localparam int DISP_SEG_FRAME_BITS = 64;
  localparam int DISP_LED_FRAME_BITS = 16;

  // A frame counter must reach FRAME_BITS+1 so that an overrun can be told apart from a full frame.
  function automatic int count_width(input int frame_bits);
    return $clog2(frame_bits + 2);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge detect.
// level and rise refer to the same sample, so a data line and a clock line stay aligned.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              edge_reg;
  logic              rise_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      edge_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
      edge_reg <= sync_reg[STAGES-1];
      rise_reg <= sync_reg[STAGES-1] & ~edge_reg;
    end
  end

  assign level = edge_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/seg_serial_rx.sv
// Oversampling receiver for the display link: deserializes one frame per
// latch strobe and flags latches that arrive with the wrong bit count.
module seg_serial_rx
  import disp_link_pkg::*;
#(
  parameter int FRAME_BITS  = DISP_SEG_FRAME_BITS,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ser_clk,
  input  logic                                 ser_do,
  input  logic                                 ser_en,
  input  logic                                 ser_clr_n,
  output logic [FRAME_BITS-1:0]                frame_data,
  output logic                                 frame_valid,
  output logic                                 frame_err,
  output logic [count_width(FRAME_BITS)-1:0]   bit_count
);

  localparam int CW = count_width(FRAME_BITS);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FRAME_BITS);
  localparam logic [CW-1:0] SAT_COUNT  = CW'(FRAME_BITS + 1);

  logic clk_rise, do_level, en_rise, clr_n_level;
  logic clk_level_unused, do_rise_unused, en_level_unused, clr_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .d(ser_clk), .level(clk_level_unused), .rise(clk_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_do (
    .clk(clk), .rst(rst), .d(ser_do), .level(do_level), .rise(do_rise_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk(clk), .rst(rst), .d(ser_en), .level(en_level_unused), .rise(en_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .rst(rst), .d(ser_clr_n), .level(clr_n_level), .rise(clr_rise_unused)
  );

  rx_state_t             state_reg, state_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [FRAME_BITS-1:0] data_reg, data_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  valid_reg, valid_next;
  logic                  err_reg, err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      data_reg  <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    count_next = count_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    if (!clr_n_level) begin
      state_next = IDLE;
      shift_next = '0;
      data_next  = '0;
      count_next = '0;
    end else begin
      // A bit arriving in the same cycle as the latch belongs to the frame being latched.
      if (clk_rise) begin
        shift_next = MSB_FIRST ? {shift_reg[FRAME_BITS-2:0], do_level}
                               : {do_level, shift_reg[FRAME_BITS-1:1]};
        count_next = (count_reg == SAT_COUNT) ? count_reg : count_reg + 1'b1;
        state_next = SHIFT;
      end
      if (en_rise) begin
        if (state_next == SHIFT && count_next == FULL_COUNT) begin
          data_next  = shift_next;
          valid_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
        count_next = '0;
        state_next = IDLE;
      end
    end
  end

  assign frame_data  = data_reg;
  assign frame_valid = valid_reg;
  assign frame_err   = err_reg;
  assign bit_count   = count_reg;

endmodule

// File: tb/tb_seg_serial_rx.sv
// Drives one link stream into a 64-bit MSB-first and a 16-bit LSB-first receiver
// and checks both against a bit-queue model of the frame rules.
module tb_seg_serial_rx;
  import disp_link_pkg::*;

  localparam int NA = DISP_SEG_FRAME_BITS;
  localparam int NB = DISP_LED_FRAME_BITS;

  logic clk;
  logic rst, ser_clk, ser_do, ser_en, ser_clr_n;
  logic [NA-1:0]               a_data;
  logic                        a_valid, a_err;
  logic [count_width(NA)-1:0]  a_count;
  logic [NB-1:0]               b_data;
  logic                        b_valid, b_err;
  logic [count_width(NB)-1:0]  b_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg_serial_rx #(.FRAME_BITS(NA), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_do(ser_do), .ser_en(ser_en),
    .ser_clr_n(ser_clr_n), .frame_data(a_data), .frame_valid(a_valid),
    .frame_err(a_err), .bit_count(a_count)
  );

  seg_serial_rx #(.FRAME_BITS(NB), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_do(ser_do), .ser_en(ser_en),
    .ser_clr_n(ser_clr_n), .frame_data(b_data), .frame_valid(b_valid),
    .frame_err(b_err), .bit_count(b_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit bits_q[$];
  logic [NA-1:0] exp_a;
  logic [NB-1:0] exp_b;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt(input int n, input bit clr_active);
    if (clr_active) return 0;
    return (bits_q.size() > n) ? n + 1 : bits_q.size();
  endfunction

  // One ser_clk period: data set while low, 4 clk low, 4 clk high.
  task automatic send_bit(input bit b, input bit clr_active);
    ser_do = b;
    tick(4);
    ser_clk = 1'b1;
    tick(4);
    ser_clk = 1'b0;
    if (!clr_active) bits_q.push_back(b);
    check_eq("a_count", 64'(a_count), 64'(exp_cnt(NA, clr_active)));
    check_eq("b_count", 64'(b_count), 64'(exp_cnt(NB, clr_active)));
  endtask

  task automatic send_word(input logic [63:0] w, input int nbits, input bit msb);
    for (int i = 0; i < nbits; i++)
      send_bit(msb ? w[nbits-1-i] : w[i], 1'b0);
  endtask

  task automatic send_random(input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Raise ser_en (optionally together with a final ser_clk edge) and watch both receivers.
  task automatic do_latch(input bit with_bit, input bit b);
    int a_v = 0, a_e = 0, a_at = 0, b_v = 0, b_e = 0, b_at = 0, both = 0;
    bit exp_av, exp_bv;
    if (with_bit) begin
      ser_do = b;
      tick(4);
      bits_q.push_back(b);
    end
    exp_av = (bits_q.size() == NA);
    exp_bv = (bits_q.size() == NB);
    if (exp_av) for (int i = 0; i < NA; i++) exp_a[NA-1-i] = bits_q[i];
    if (exp_bv) for (int i = 0; i < NB; i++) exp_b[i] = bits_q[i];
    if (with_bit) ser_clk = 1'b1;
    ser_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if ((a_valid || a_err) && a_at == 0) a_at = i;
      if ((b_valid || b_err) && b_at == 0) b_at = i;
      a_v += int'(a_valid);
      a_e += int'(a_err);
      b_v += int'(b_valid);
      b_e += int'(b_err);
      if ((a_valid && a_err) || (b_valid && b_err)) both++;
      if (a_valid) check_eq("a_data_at_valid", 64'(a_data), 64'(exp_a));
      if (b_valid) check_eq("b_data_at_valid", 64'(b_data), 64'(exp_b));
      if (i == 4) begin
        ser_clk = 1'b0;
        ser_en  = 1'b0;
      end
    end
    check_eq("a_latency", 64'(a_at), 64'd4);
    check_eq("b_latency", 64'(b_at), 64'd4);
    check_eq("a_valid_pulses", 64'(a_v), exp_av ? 64'd1 : 64'd0);
    check_eq("a_err_pulses", 64'(a_e), exp_av ? 64'd0 : 64'd1);
    check_eq("b_valid_pulses", 64'(b_v), exp_bv ? 64'd1 : 64'd0);
    check_eq("b_err_pulses", 64'(b_e), exp_bv ? 64'd0 : 64'd1);
    check_eq("valid_err_overlap", 64'(both), 64'd0);
    check_eq("a_data_held", 64'(a_data), 64'(exp_a));
    check_eq("b_data_held", 64'(b_data), 64'(exp_b));
    check_eq("a_count_after_latch", 64'(a_count), 64'd0);
    check_eq("b_count_after_latch", 64'(b_count), 64'd0);
    $display("[TB] latch bits=%0d a:%s data=%h b:%s data=%h", bits_q.size(),
             exp_av ? "valid" : "err", a_data, exp_bv ? "valid" : "err", b_data);
    bits_q.delete();
    tick(4);
  endtask

  task automatic do_clear(input int periods);
    ser_clr_n = 1'b0;
    tick(6);
    bits_q.delete();
    exp_a = '0;
    exp_b = '0;
    check_eq("a_data_clear", 64'(a_data), 64'd0);
    check_eq("b_data_clear", 64'(b_data), 64'd0);
    for (int i = 0; i < periods; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
    ser_clr_n = 1'b1;
    tick(6);
    $display("[TB] clear for %0d ser_clk periods", periods);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    bits_q.delete();
    exp_a = '0;
    exp_b = '0;
    rst = 1'b0;
    tick(6);
    $display("[TB] reset");
  endtask

  initial begin
    int len;
    logic [63:0] w;
    rst = 1'b1; ser_clk = 1'b0; ser_do = 1'b0; ser_en = 1'b0; ser_clr_n = 1'b1;
    exp_a = '0;
    exp_b = '0;
    tick(3);
    check_eq("rst_a_data", 64'(a_data), 64'd0);
    check_eq("rst_a_valid", 64'(a_valid), 64'd0);
    check_eq("rst_a_err", 64'(a_err), 64'd0);
    check_eq("rst_a_count", 64'(a_count), 64'd0);
    check_eq("rst_b_data", 64'(b_data), 64'd0);
    check_eq("rst_b_count", 64'(b_count), 64'd0);
    rst = 1'b0;
    tick(6);

    // Nominal, short and overrun frames.
    send_word(64'hDEADBEEF_01234567, NA, 1'b1);
    do_latch(1'b0, 1'b0);
    send_random(NA - 1);
    do_latch(1'b0, 1'b0);
    send_random(70);
    do_latch(1'b0, 1'b0);

    // Clear mid-frame, then a full frame.
    send_random(30);
    do_clear(4);
    send_word(64'h0123456789ABCDEF, NA, 1'b1);
    do_latch(1'b0, 1'b0);

    // Reset mid-frame, then a full frame.
    send_random(40);
    do_reset();
    w = {$urandom, $urandom};
    send_word(w, NA, 1'b1);
    do_latch(1'b0, 1'b0);

    // Last ser_clk edge coincident with the latch edge.
    w = {$urandom, $urandom};
    send_word(w >> 1, NA - 1, 1'b1);
    do_latch(1'b1, w[0]);

    // LSB-first LED word, plain and with a coincident final bit.
    send_word(64'hA5C3, NB, 1'b0);
    do_latch(1'b0, 1'b0);
    w = 64'($urandom);
    send_word(w, NB - 1, 1'b0);
    do_latch(1'b1, w[NB-1]);

    // Latch with no bits shifted.
    do_latch(1'b0, 1'b0);

    // Randomized frame lengths around both frame sizes.
    for (int r = 0; r < 10; r++) begin
      case ($urandom_range(0, 4))
        0: len = NA;
        1: len = NB;
        2: len = NA - 1 + 2 * int'($urandom_range(0, 1));
        3: len = NB - 1 + 2 * int'($urandom_range(0, 1));
        default: len = int'($urandom_range(1, 70));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        send_random(len - 1);
        do_latch(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        send_random(len);
        do_latch(1'b0, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
